// File: rtl/posit_add_stream_es3_pkg.sv
// Shared constants and result record for the ES=3 posit adder stream wrapper.
// Defining POSIT_ADD_TAG_EN adds a sideband tag field to add_result_t.
package posit_defines_es3;
  localparam int POSIT_ADD_LATENCY = 8;
  localparam int POSIT_ADD_TAG_W   = 8;

  typedef struct packed {
`ifdef POSIT_ADD_TAG_EN
    logic [POSIT_ADD_TAG_W-1:0] tag;
`endif
    logic [31:0] result;
    logic        inf;
    logic        zero;
  } add_result_t;
endpackage

// File: rtl/posit_add_stream_es3_fifo.sv
// Synchronous DEPTH-entry result FIFO: head read straight from registered storage.
// The caller guarantees no push when full and no pop when empty.
module posit_result_fifo
  import posit_defines_es3::*;
#(
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  add_result_t   wdata_i,
  input  logic          pop_i,
  output add_result_t   head_o,
  output logic [CW-1:0] count_o
);
  add_result_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Payload needs no reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/posit_add_stream_es3.sv
// Valid/ready wrapper around the fixed-latency posit adder with credit-based result FIFO.
// POSIT_ADD_TAG_EN adds in_tag/out_tag and a tag delay line matched to the adder latency.
module posit_add_stream_es3
  import posit_defines_es3::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADD_LATENCY = POSIT_ADD_LATENCY,
  parameter int TAG_W       = POSIT_ADD_TAG_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
`ifdef POSIT_ADD_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
`endif
  output logic [31:0]      add_in1,
  output logic [31:0]      add_in2,
  output logic             add_start,
  input  logic [31:0]      add_result,
  input  logic             add_inf,
  input  logic             add_zero,
  input  logic             add_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_inf,
  output logic             out_zero,
`ifdef POSIT_ADD_TAG_EN
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic             err_orphan
);
  localparam int CW = $clog2(DEPTH + 1);

  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < ADD_LATENCY || TAG_W < 1) begin : g_bad_cfg
    $error("posit_add_stream_es3: DEPTH must be a power of two and >= ADD_LATENCY");
  end

  logic [CW-1:0] inflight_q, inflight_d, fifo_count;
  logic [CW:0]   credit_sum;
  logic          err_orphan_q, accept, ret, pop;
  add_result_t   wdata, head;

  // Credits come from registered counters only, so out_ready never reaches in_ready.
  assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign in_ready   = credit_sum < (CW+1)'(DEPTH);
  assign accept     = in_valid & in_ready;
  assign add_start  = accept;
  assign add_in1    = in_a;
  assign add_in2    = in_b;
  assign ret        = add_done & (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, ret})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      err_orphan_q <= err_orphan_q | (add_done & (inflight_q == '0));
    end
  end

`ifdef POSIT_ADD_TAG_EN
  logic [ADD_LATENCY-1:0][TAG_W-1:0] tag_sr_q;

  // Idle slots shift in zero so the tap lines up with add_done for each issued op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_sr_q <= '0;
    end else begin
      tag_sr_q[0] <= accept ? in_tag : '0;
      for (int i = 1; i < ADD_LATENCY; i++) tag_sr_q[i] <= tag_sr_q[i-1];
    end
  end
`endif

  always_comb begin
    wdata        = '0;
    wdata.result = add_result;
    wdata.inf    = add_inf;
    wdata.zero   = add_zero;
`ifdef POSIT_ADD_TAG_EN
    wdata.tag    = tag_sr_q[ADD_LATENCY-1];
`endif
  end

  assign pop = out_valid & out_ready;

  posit_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (ret),
    .wdata_i (wdata),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count)
  );

  assign out_valid  = fifo_count != '0;
  assign out_result = head.result;
  assign out_inf    = head.inf;
  assign out_zero   = head.zero;
`ifdef POSIT_ADD_TAG_EN
  assign out_tag    = head.tag;
`endif
  assign err_orphan = err_orphan_q;
endmodule

// File: tb/tb_posit_add_stream_es3.sv
// Bench for posit_add_stream_es3: adder stand-in with fixed latency, queue model of
// issue-order results and credit-based in_ready, randomized operands and out_ready.
`timescale 1ns/1ps
module tb_posit_add_stream_es3;
  localparam int DEPTH = 16;
  localparam int LAT   = 8;

  logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [7:0]  in_tag_v = '0;
  logic        in_ready, add_start, add_inf, add_zero, add_done;
  logic [31:0] add_in1, add_in2, add_result;
  logic        out_valid, out_inf, out_zero, err_orphan;
  logic [31:0] out_result;
`ifdef POSIT_ADD_TAG_EN
  logic [7:0]  out_tag;
`endif

  int n_vec = 0, n_err = 0, pops = 0;
  bit rnd_mode = 1'b0, ready_set = 1'b1;
  logic stray_done = 1'b0;
  logic [31:0] last_res = '0;
  logic last_inf = 1'b0, last_zero = 1'b0;

  always #5 clk = ~clk;

  posit_add_stream_es3 dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
`ifdef POSIT_ADD_TAG_EN
    .in_tag(in_tag_v),
`endif
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_inf(out_inf), .out_zero(out_zero),
`ifdef POSIT_ADD_TAG_EN
    .out_tag(out_tag),
`endif
    .err_orphan(err_orphan)
  );

  // Adder stand-in: exact answers for the documented vectors, integer sum as a token otherwise.
  function automatic logic [33:0] adder_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    if (a == 32'h8000_0000 || b == 32'h8000_0000) return {32'h8000_0000, 2'b10};
    if (a == 32'h4000_0000 && b == 32'h4000_0000) return {32'h4400_0000, 2'b00};
    s = a + b;
    if (s == 32'h8000_0000) s = 32'h7fff_ffff;
    return {s, 1'b0, s == 32'h0};
  endfunction

  // Fixed-latency pipe; deliberately not reset so a mid-op reset leaves stray dones.
  logic [LAT-1:0]       pv = '0;
  logic [LAT-1:0][33:0] pd = '0;
  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], add_start};
    pd <= {pd[LAT-2:0], adder_ref(add_in1, add_in2)};
  end
  assign add_done = pv[LAT-1] | stray_done;
  assign {add_result, add_inf, add_zero} = pd[LAT-1];

  initial forever begin
    @(posedge clk); #2;
    out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_set;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of {result,inf,zero,tag} in issue order; its size is the credit count.
  logic [41:0] exp_q[$];
  always @(negedge clk) begin
    logic exp_rdy;
    logic [41:0] e;
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      exp_rdy = exp_q.size() < DEPTH;
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      chk("add_start", {31'b0, add_start}, {31'b0, in_valid & exp_rdy});
      if (add_start) begin
        chk("add_in1", add_in1, in_a);
        chk("add_in2", add_in2, in_b);
      end
      if (out_valid) chk("valid_has_pending", {31'b0, exp_q.size() != 0}, 32'd1);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_result", out_result, e[41:10]);
        chk("out_inf", {31'b0, out_inf}, {31'b0, e[9]});
        chk("out_zero", {31'b0, out_zero}, {31'b0, e[8]});
`ifdef POSIT_ADD_TAG_EN
        chk("out_tag", {24'b0, out_tag}, {24'b0, e[7:0]});
`endif
        last_res = out_result; last_inf = out_inf; last_zero = out_zero;
        pops++;
      end
      if (in_valid && in_ready) exp_q.push_back({adder_ref(in_a, in_b), in_tag_v});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] t,
                      input int budget, output bit ok);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag_v = t;
    @(negedge clk);
    while (!in_ready && n < budget) begin @(negedge clk); n++; end
    ok = in_ready;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, acc, p0;
    #1;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_err_orphan", {31'b0, err_orphan}, 32'd0);
    tick(); reset_n = 1'b1; tick(); tick();

    // Single op: 1.0 + 1.0, out_valid expected 9 cycles after the accept cycle.
    send(32'h4000_0000, 32'h4000_0000, 8'h00, 20, ok);
    chk("single_accept", {31'b0, ok}, 32'd1);
    n = 1;
    while (n < 30) begin
      @(negedge clk);
      if (out_valid) break;
      tick(); n++;
    end
    chk("single_latency", n, 32'd9);
    chk("single_result", out_result, 32'h4400_0000);
    chk("single_inf", {31'b0, out_inf}, 32'd0);
    chk("single_zero", {31'b0, out_zero}, 32'd0);
    repeat (3) tick();

    // Burst: 32 back-to-back with out_ready high, never stalled.
    p0 = pops;
    for (int i = 0; i < 32; i++) begin
      send($urandom, $urandom, 8'(i), 0, ok);
      chk("burst_ready", {31'b0, ok}, 32'd1);
    end
    repeat (12) tick();
    chk("burst_pops", pops - p0, 32'd32);

    // Backpressure: exactly DEPTH accepted, then drain restores credit.
    ready_set = 1'b0; tick();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      send($urandom, $urandom, 8'(i), 3, ok);
      if (!ok) break;
      acc++;
    end
    chk("bp_accepted", acc, DEPTH);
    repeat (10) tick();
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    p0 = pops;
    ready_set = 1'b1;
    repeat (20) tick();
    chk("bp_drained", pops - p0, DEPTH);
    chk("bp_in_ready_back", {31'b0, in_ready}, 32'd1);

    // Special values.
    send(32'h8000_0000, 32'h4000_0000, 8'h00, 20, ok);
    repeat (12) tick();
    chk("nar_result", last_res, 32'h8000_0000);
    chk("nar_inf", {31'b0, last_inf}, 32'd1);
    chk("nar_zero", {31'b0, last_zero}, 32'd0);
    send(32'h0, 32'h0, 8'h00, 20, ok);
    repeat (12) tick();
    chk("zero_result", last_res, 32'h0);
    chk("zero_zero", {31'b0, last_zero}, 32'd1);
    chk("zero_inf", {31'b0, last_inf}, 32'd0);

    // Orphan with nothing in flight.
    stray_done = 1'b1; tick(); stray_done = 1'b0; tick();
    chk("orphan_flag", {31'b0, err_orphan}, 32'd1);
    chk("orphan_no_push", {31'b0, out_valid}, 32'd0);
    do_reset(); tick();
    chk("orphan_cleared", {31'b0, err_orphan}, 32'd0);

    // Reset with 5 ops in flight: their dones must become orphans.
    for (int i = 0; i < 5; i++) send($urandom, $urandom, 8'(i), 0, ok);
    tick();
    do_reset();
    @(negedge clk);
    chk("midrst_err_low", {31'b0, err_orphan}, 32'd0);
    repeat (10) tick();
    chk("midrst_err_set", {31'b0, err_orphan}, 32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);

    // Tagged 32-op burst then random traffic, all under random out_ready.
    rnd_mode = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      send($urandom, $urandom, 8'(i), 64, ok);
      chk("tagburst_accept", {31'b0, ok}, 32'd1);
    end
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send($urandom, ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
           8'($urandom), 64, ok);
      chk("rand_accept", {31'b0, ok}, 32'd1);
    end
    rnd_mode = 1'b0; ready_set = 1'b1;
    repeat (30) tick();
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("drain_out_valid", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
